mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares the single memory port (readM/writeM/address/data, inputReady/ackOutput handshake) between the datapath's instruction-fetch requester and its data-access requester. It sits between the CPU datapath and the memory model, serialises transactions, drives the memory handshake, and returns read data and a one-cycle completion pulse to the granted requester. Data accesses have priority, with a starvation guard that protects instruction fetch.

## Interface
- WORD_SIZE, 16, width of address and data words (shared with `WORD_SIZE`).
- STARVE_LIMIT, 4, number of consecutive data grants after which a pending fetch wins the next arbitration (range 1-15).

- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- i_req  in  1  fetch request, level, held until i_done.
- i_address  in  WORD_SIZE  fetch address (PC), stable while i_req high.
- i_rdata  out  WORD_SIZE  fetched word, valid in the i_done cycle and held until the next fetch completes.
- i_done  out  1  one-cycle fetch completion pulse.
- d_read  in  1  data read request, level.
- d_write  in  1  data write request, level.
- d_address  in  WORD_SIZE  data address (ALU output).
- d_wdata  in  WORD_SIZE  write data; must be stable while d_write is high.
- d_rdata  out  WORD_SIZE  read data, valid in the d_done cycle and held until the next data read completes.
- d_done  out  1  one-cycle data completion pulse (read or write).
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  memory data bus; driven only in WRITE, otherwise high-Z.
- inputReady  in  1  memory read-data-valid.
- ackOutput  in  1  memory write acknowledge.

## Operation
- FSM states: IDLE, READ_I, READ_D, WRITE_D, RELEASE.
- IDLE arbitration, evaluated each cycle:
  - a data request wins over i_req, unless i_req is high and starve_cnt >= STARVE_LIMIT, in which case the fetch wins.
  - If d_read and d_write are both high, the request is served as a write.
- READ_I / READ_D:
  - readM=1 and address = latched request address.
  - On the first edge with inputReady=1: capture data into i_rdata or d_rdata, pulse the matching done signal, and go to RELEASE.
- WRITE_D:
  - writeM=1, data = latched d_wdata, address = latched d_address.
  - On the first edge with ackOutput=1: pulse d_done and go to RELEASE.
- RELEASE:
  - Strobes and bus released.
  - Stay here until inputReady=0 and ackOutput=0, then go to IDLE.
- Address and write data are latched at grant. Requester changes after grant are ignored.
- A requester dropping its request mid-transaction does not abort it: the transaction completes and the done pulse is still issued.
- starve_cnt (4-bit):
  - increments on each data grant made while i_req is high, saturating at 15;
  - clears on any fetch grant;
  - is left unchanged by a data grant made while i_req is low.

## Timing
- Reset values: readM=0, writeM=0, address=0, data=Z, i_done=0, d_done=0, i_rdata=0, d_rdata=0, state=IDLE, starve_cnt=0.
- Reset mid-transaction:
  - strobes drop and the bus floats at the next edge;
  - no done pulse is issued;
  - captured data is discarded.
- All outputs are registered.
- Grant at edge N (in IDLE): the strobe is high after edge N.
- inputReady or ackOutput sampled high at edge M: the done pulse and data are visible after edge M, and the strobe is low after edge M.
- Minimum transaction with a zero-wait memory is 3 cycles: grant, complete, release.
- The next grant comes at the earliest one cycle after RELEASE exits.
- done pulses are exactly 1 cycle wide. i_done and d_done are never high in the same cycle.
- A request still held after its done pulse is treated as a new request in IDLE. Requesters must drop their request in the done cycle.

## Structure
- Shared header `mem_arb_defs.v`: FSM state encodings (3-bit) and STARVE_LIMIT default; reuses `WORD_SIZE` from opcodes.v.
- Single module, no sub-module; the starvation counter and data capture registers are inline.

## Test plan
- Reset:
  - Stimulus: reset_n=0 for 2 cycles, with i_req=1 held.
  - Required: all outputs at reset values, data=Z; the first grant comes in the first cycle after reset_n=1.
- Lone fetch:
  - Stimulus: i_address=0x0004; memory returns 0xA123 with 2 wait cycles.
  - Required: readM high for 3 cycles, address=0x0004, i_rdata=0xA123 with one i_done pulse, then RELEASE.
- Simultaneous requests:
  - Stimulus: i_req and d_read at 0x0010 asserted together.
  - Required: data read first (d_done), fetch granted after release, order d_done then i_done.
- Write handshake:
  - Stimulus: d_write, d_address=0x0020, d_wdata=0x5A5A, ackOutput after 1 cycle.
  - Required: data=0x5A5A only while writeM=1, d_done pulsed once, bus Z afterwards.
- Starvation:
  - Stimulus: d_read held continuously, i_req held, STARVE_LIMIT=4.
  - Required: exactly 4 data grants, then a fetch grant, then data resumes.
- Abort:
  - Stimulus: reset_n=0 while READ_D waits for inputReady.
  - Required: readM=0 the next cycle, no d_done, d_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, default sizes
// and the saturating starvation-counter helper.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD_SIZE    = 16;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ_I  = 3'd1,
    ST_READ_D  = 3'd2,
    ST_WRITE_D = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == {STARVE_W{1'b1}}) ? cnt : cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins arbitration unless fetch has waited STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output arb_state_e           dbg_state
);

  // Requesters hold a level request until their one-cycle done pulse and drop
  // it in that cycle; the grant latches address/write data, so later changes
  // are ignored and a dropped request still completes.
  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic [STARVE_W-1:0]  cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic                 d_req;
  logic                 fetch_wins;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    d_req      = d_read | d_write;
    fetch_wins = i_req & (~d_req | (cnt_q >= LIMIT_C));

    case (state_q)
      ST_IDLE: begin
        if (fetch_wins) begin
          state_d = ST_READ_I;
          rd_d    = 1'b1;
          addr_d  = i_address;
          cnt_d   = '0;
        end else if (d_req) begin
          addr_d = d_address;
          if (i_req) cnt_d = starve_inc(cnt_q);
          // A simultaneous read+write request is served as a write.
          if (d_write) begin
            state_d = ST_WRITE_D;
            wr_d    = 1'b1;
            wdata_d = d_wdata;
          end else begin
            state_d = ST_READ_D;
            rd_d    = 1'b1;
          end
        end
      end
      ST_READ_I: begin
        if (inputReady) begin
          i_rdata_d = data;
          i_done_d  = 1'b1;
          rd_d      = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_READ_D: begin
        if (inputReady) begin
          d_rdata_d = data;
          d_done_d  = 1'b1;
          rd_d      = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_WRITE_D: begin
        if (ackOutput) begin
          d_done_d = 1'b1;
          wr_d     = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the memory to drop its handshake before re-arbitrating.
        if (!inputReady && !ackOutput) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign data      = wr_q ? wdata_q : {WORD_SIZE{1'bz}};
  assign readM     = rd_q;
  assign writeM    = wr_q;
  assign address   = addr_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign dbg_state = state_q;

endmodule
